// File: rtl/counter_99999999_controller.sv
`default_nettype none
// ============================================================================
// Module      : counter_99999999_controller
// Description : Run/stop/load sequencer for the 8-digit counter; divides the
//               system clock to 1 Hz and debounces the board buttons.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_99999999_controller #(
    parameter int HALF_PERIOD = 50_000_000,
    parameter int DEBOUNCE    = 1_000_000,
    parameter int CLEAR_PULSE = 4,
    parameter int MAX_COUNT   = 99_999_999
) (
    input  logic        Clock_100MHz,
    input  logic        Reset,
    input  logic        Btn_start,
    input  logic        Btn_dir,
    input  logic        Btn_load,
    input  logic        Btn_clear,
    input  logic [26:0] Switch_data,
    output logic        Clock_1Hz,
    output logic        Enable,
    output logic        Up_down,
    output logic        Load,
    output logic [26:0] Data,
    output logic        Clear_n,
    output logic        Running
);

    localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int DB_W  = (DEBOUNCE > 1)    ? $clog2(DEBOUNCE)    : 1;
    localparam int CP_W  = (CLEAR_PULSE > 1) ? $clog2(CLEAR_PULSE) : 1;

    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(HALF_PERIOD - 1);
    localparam logic [DB_W-1:0]  c_DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [CP_W-1:0]  c_CP_LAST  = CP_W'(CLEAR_PULSE - 1);
    localparam logic [26:0]      c_MAX      = 27'(MAX_COUNT);

    localparam logic [1:0] c_ST_STOPPED = 2'd0;
    localparam logic [1:0] c_ST_RUNNING = 2'd1;
    localparam logic [1:0] c_ST_LOAD    = 2'd2;

    // ------------------------------------------------------------------
    // Clock divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic             r_clk1hz;
    logic             w_tc;
    logic             w_fall_evt;

    assign w_tc       = (r_div == c_DIV_LAST);
    assign w_fall_evt = w_tc & r_clk1hz;

    always_ff @(posedge Clock_100MHz or posedge Reset) begin
        if (Reset) begin
            r_div    <= '0;
            r_clk1hz <= 1'b0;
        end else if (w_tc) begin
            r_div    <= '0;
            r_clk1hz <= ~r_clk1hz;
        end else begin
            r_div    <= r_div + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Button synchronizers and debouncers: bit 0 start, 1 dir, 2 load, 3 clear
    // ------------------------------------------------------------------
    logic [3:0] w_btn_raw;
    logic [3:0] w_press;

    assign w_btn_raw = {Btn_clear, Btn_load, Btn_dir, Btn_start};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic            r_s1;
            logic            r_s2;
            logic            r_lvl;
            logic            r_lvl_q;
            logic [DB_W-1:0] r_cnt;

            always_ff @(posedge Clock_100MHz or posedge Reset) begin
                if (Reset) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_lvl   <= 1'b0;
                    r_lvl_q <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_s1    <= w_btn_raw[gi];
                    r_s2    <= r_s1;
                    r_lvl_q <= r_lvl;
                    if (r_s2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_lvl <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_lvl & ~r_lvl_q;
        end
    endgenerate

    logic w_press_start;
    logic w_press_dir;
    logic w_press_load;
    logic w_press_clear;

    assign w_press_start = w_press[0];
    assign w_press_dir   = w_press[1];
    assign w_press_load  = w_press[2];
    assign w_press_clear = w_press[3];

    // ------------------------------------------------------------------
    // Pending flags and run/stop/load FSM
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_ret;
    logic        w_ret_nxt;
    logic        r_start_p;
    logic        w_start_p_nxt;
    logic        r_dir_p;
    logic        w_dir_p_nxt;
    logic        r_load_p;
    logic        w_load_p_nxt;
    logic        r_up_down;
    logic        w_ud_nxt;
    logic        w_enter_load;
    logic        r_enable;
    logic        r_load;
    logic [26:0] r_data;
    logic [26:0] w_clamped;

    assign w_clamped = (Switch_data > c_MAX) ? c_MAX : Switch_data;

    always_comb begin
        w_state_nxt   = r_state;
        w_ret_nxt     = r_ret;
        w_enter_load  = 1'b0;
        w_ud_nxt      = r_up_down;
        w_start_p_nxt = r_start_p ^ w_press_start;
        w_dir_p_nxt   = r_dir_p ^ w_press_dir;
        w_load_p_nxt  = (r_load_p | w_press_load) & ~w_press_clear;

        if (w_fall_evt) begin
            // Presses coinciding with the fall are held for the next one
            w_ud_nxt      = r_up_down ^ r_dir_p;
            w_dir_p_nxt   = w_press_dir;
            w_start_p_nxt = w_press_start;
            w_load_p_nxt  = w_press_load & ~w_press_clear;
            if (r_state == c_ST_LOAD) begin
                w_ret_nxt   = r_ret ^ r_start_p;
                w_state_nxt = w_ret_nxt ? c_ST_RUNNING : c_ST_STOPPED;
            end else if (r_load_p && !w_press_clear) begin
                // A start pending alongside the load is applied on LOAD exit
                w_enter_load  = 1'b1;
                w_state_nxt   = c_ST_LOAD;
                w_ret_nxt     = (r_state == c_ST_RUNNING);
                w_start_p_nxt = w_press_start ^ r_start_p;
            end else if (r_start_p) begin
                w_state_nxt = (r_state == c_ST_RUNNING) ? c_ST_STOPPED : c_ST_RUNNING;
            end
        end else if (w_press_clear && (r_state == c_ST_LOAD)) begin
            w_state_nxt = r_ret ? c_ST_RUNNING : c_ST_STOPPED;
        end
    end

    always_ff @(posedge Clock_100MHz or posedge Reset) begin
        if (Reset) begin
            r_state   <= c_ST_STOPPED;
            r_ret     <= 1'b0;
            r_start_p <= 1'b0;
            r_dir_p   <= 1'b0;
            r_load_p  <= 1'b0;
            r_up_down <= 1'b1;
            r_enable  <= 1'b0;
            r_load    <= 1'b0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ret     <= w_ret_nxt;
            r_start_p <= w_start_p_nxt;
            r_dir_p   <= w_dir_p_nxt;
            r_load_p  <= w_load_p_nxt;
            r_up_down <= w_ud_nxt;
            r_enable  <= (w_state_nxt == c_ST_RUNNING) |
                         ((w_state_nxt == c_ST_LOAD) & w_ret_nxt);
            r_load    <= (w_state_nxt == c_ST_LOAD);
            if (w_enter_load) begin
                r_data <= w_clamped;
            end
        end
    end

    // ------------------------------------------------------------------
    // Clear pulse generator; held low through reset and released one clock after
    // ------------------------------------------------------------------
    logic            r_clear_n;
    logic [CP_W-1:0] r_clr_cnt;

    always_ff @(posedge Clock_100MHz or posedge Reset) begin
        if (Reset) begin
            r_clear_n <= 1'b0;
            r_clr_cnt <= '0;
        end else if (w_press_clear) begin
            r_clear_n <= 1'b0;
            r_clr_cnt <= c_CP_LAST;
        end else if (!r_clear_n) begin
            if (r_clr_cnt == '0) begin
                r_clear_n <= 1'b1;
            end else begin
                r_clr_cnt <= r_clr_cnt - 1'b1;
            end
        end
    end

    assign Clock_1Hz = r_clk1hz;
    assign Enable    = r_enable;
    assign Running   = r_enable;
    assign Up_down   = r_up_down;
    assign Load      = r_load;
    assign Data      = r_data;
    assign Clear_n   = r_clear_n;

endmodule
`default_nettype wire

// File: tb/tb_counter_99999999_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_99999999_controller
// Description : Directed plus random stimulus against a cycle-level
//               behavioural model of the counter controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_99999999_controller;

    localparam int HALF = 4;
    localparam int DEB  = 3;
    localparam int CPUL = 4;
    localparam int MAXC = 99_999_999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  btn = 4'b0;   // 0 start, 1 dir, 2 load, 3 clear
    logic [26:0] sw  = '0;
    logic        clk1hz, en, ud, ld, clrn, running;
    logic [26:0] data;

    counter_99999999_controller #(
        .HALF_PERIOD(HALF), .DEBOUNCE(DEB), .CLEAR_PULSE(CPUL), .MAX_COUNT(MAXC)
    ) dut (
        .Clock_100MHz(clk), .Reset(rst),
        .Btn_start(btn[0]), .Btn_dir(btn[1]), .Btn_load(btn[2]), .Btn_clear(btn[3]),
        .Switch_data(sw),
        .Clock_1Hz(clk1hz), .Enable(en), .Up_down(ud), .Load(ld),
        .Data(data), .Clear_n(clrn), .Running(running)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: edge count since reset release, run status, loading flag
    int          n;
    bit          run_m, load_m, ud_m, sp, dp, lp;
    logic [26:0] data_m;
    int          clr_left;
    bit          lvl_m  [4];
    bit          rose_m [4];
    bit          hist   [4][5];

    task automatic model_reset();
        n = 0; run_m = 0; load_m = 0; ud_m = 1; sp = 0; dp = 0; lp = 0;
        data_m = '0; clr_left = 1;
        for (int b = 0; b < 4; b++) begin
            lvl_m[b] = 0; rose_m[b] = 0;
            for (int k = 0; k < 5; k++) hist[b][k] = 0;
        end
    endtask

    // Advance the model across one rising clock edge with the present inputs
    task automatic model_step();
        bit pr [4];
        bit fall;
        n++;
        fall = (n % (2 * HALF) == 0);
        for (int b = 0; b < 4; b++) begin
            pr[b] = rose_m[b];
            for (int k = 4; k > 0; k--) hist[b][k] = hist[b][k-1];
            hist[b][0] = btn[b];
            rose_m[b] = 0;
            // A level is accepted after three synchronized samples all disagree with it
            if (hist[b][2] != lvl_m[b] && hist[b][3] != lvl_m[b] && hist[b][4] != lvl_m[b]) begin
                lvl_m[b]  = !lvl_m[b];
                rose_m[b] = lvl_m[b];
            end
        end
        if (pr[3]) clr_left = CPUL;
        else if (clr_left > 0) clr_left--;

        if (fall) begin
            bit keep_sp;
            keep_sp = 0;
            if (load_m) begin
                load_m = 0;
                if (sp) run_m = !run_m;
            end else if (lp && !pr[3]) begin
                load_m = 1;
                data_m = (sw > 27'(MAXC)) ? 27'(MAXC) : sw;
                keep_sp = sp;
            end else if (sp) begin
                run_m = !run_m;
            end
            if (dp) ud_m = !ud_m;
            sp = pr[0] ^ keep_sp;
            dp = pr[1];
            lp = pr[2] && !pr[3];
        end else begin
            sp = sp ^ pr[0];
            dp = dp ^ pr[1];
            lp = (lp || pr[2]) && !pr[3];
            if (pr[3]) load_m = 0;
        end
    endtask

    function automatic bit clk_m();
        return bit'((n / HALF) % 2);
    endfunction

    task automatic check1(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        check1("Clock_1Hz", 32'(clk1hz),  32'(clk_m()));
        check1("Enable",    32'(en),      32'(run_m));
        check1("Running",   32'(running), 32'(run_m));
        check1("Up_down",   32'(ud),      32'(ud_m));
        check1("Load",      32'(ld),      32'(load_m));
        check1("Data",      32'(data),    32'(data_m));
        check1("Clear_n",   32'(clrn),    32'(clr_left == 0));
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(int cycles);
        repeat (cycles) tick();
    endtask

    task automatic press(logic [3:0] mask, int len, int gap);
        btn = mask;
        repeat (len) tick();
        btn = 4'b0;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        btn = 4'b0;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset and free-running divider
        @(negedge clk);
        do_reset();
        idle(24);

        // 2: clean start press, then a glitch too short to register
        press(4'b0001, 5, 12);
        press(4'b0001, 2, 20);

        // 3: load in-range value
        sw = 27'd12345;
        press(4'b0100, 5, 24);

        // 4: clamped load, then two dir presses inside one 1 Hz period
        sw = 27'h7FFFFFF;
        press(4'b0100, 4, 24);
        for (int i = 0; i < 8 && (n % (2 * HALF)) != 3; i++) tick();
        press(4'b0010, 3, 3);
        press(4'b0010, 3, 16);

        // 5: clear and load together
        sw = 27'd777;
        press(4'b1100, 5, 20);

        // 6: reset in the middle of a LOAD with a start pending
        sw = 27'd4242;
        press(4'b0100, 5, 0);
        for (int i = 0; i < 40 && !load_m; i++) tick();
        check1("load_reached", 32'(ld), 32'd1);
        press(4'b0001, 5, 2);
        do_reset();
        idle(24);

        // 7: random button activity
        for (int i = 0; i < 80; i++) begin
            logic [3:0] mask;
            if ($urandom_range(0, 3) == 0) mask = 4'($urandom_range(1, 15));
            else                           mask = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) sw = 27'($urandom);
            else                           sw = 27'($urandom_range(0, MAXC));
            press(mask, $urandom_range(1, 6), $urandom_range(0, 14));
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
